// File: rtl/gamma_pkg.sv
//==============================================================================
// Module   : gamma_pkg
// Brief    : Shared widths and bypass padding helper for the gamma LUT stage.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package gamma_pkg;

    localparam int DIN_W_DEFAULT  = 8;
    localparam int DOUT_W_DEFAULT = 12;
    localparam int DEPTH          = 2 ** DIN_W_DEFAULT;

    // Left-justify d into dout_w bits, filling the low bits by repeating d from its MSB down.
    function automatic logic [31:0] pad_msb(input logic [31:0] d, input int din_w,
                                            input int dout_w);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < dout_w; i++) begin
            res[dout_w - 1 - i] = d[din_w - 1 - (i % din_w)];
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gamma_dpram.sv
//==============================================================================
// Module   : gamma_dpram
// Brief    : Simple dual-port RAM, one sync write port, one registered read port.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module gamma_dpram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 12
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd_data;

    // Read-before-write: a same-address read in the write cycle returns old data.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/gamma_lut_ram.sv
//==============================================================================
// Module   : gamma_lut_ram
// Brief    : Double-banked run-time gamma table with frame-aligned bank swap.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module gamma_lut_ram
    import gamma_pkg::*;
#(
    parameter int DIN_W  = DIN_W_DEFAULT,
    parameter int DOUT_W = DOUT_W_DEFAULT
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_vs,
    input  logic              I_hs,
    input  logic              I_de,
    input  logic [DIN_W-1:0]  I_data,
    output logic              O_vs,
    output logic              O_hs,
    output logic              O_de,
    output logic [DOUT_W-1:0] O_data,
    input  logic              I_lut_wr_en,
    input  logic [DIN_W-1:0]  I_lut_wr_addr,
    input  logic [DOUT_W-1:0] I_lut_wr_data,
    input  logic              I_lut_commit,
    output logic              O_lut_busy,
    output logic              O_lut_bank,
    output logic              O_lut_valid
);

    localparam int ADDR_W = DIN_W + 1;

    logic              r_active;
    logic              r_pending;
    logic              r_valid;

    logic              r_vs_s1;
    logic              r_hs_s1;
    logic              r_de_s1;
    logic              r_valid_s1;
    logic [DIN_W-1:0]  r_data_s1;

    logic              r_vs_s2;
    logic              r_hs_s2;
    logic              r_de_s2;
    logic [DOUT_W-1:0] r_data_s2;

    logic              w_vs_rise;
    logic              w_swap;
    logic [DOUT_W-1:0] w_ram_q;
    logic [DOUT_W-1:0] w_bypass;
    logic [DOUT_W-1:0] w_pix_out;

    // r_vs_s1 doubles as the previous-cycle vs for edge detection.
    assign w_vs_rise = I_vs & ~r_vs_s1;
    assign w_swap    = w_vs_rise & r_pending;

    gamma_dpram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DOUT_W)
    ) u_ram (
        .i_clk     (I_clk),
        .i_wr_en   (I_lut_wr_en),
        .i_wr_addr ({~r_active, I_lut_wr_addr}),
        .i_wr_data (I_lut_wr_data),
        .i_rd_addr ({r_active, I_data}),
        .o_rd_data (w_ram_q)
    );

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_active  <= 1'b0;
            r_pending <= 1'b0;
            r_valid   <= 1'b0;
        end else if (w_swap) begin
            r_active  <= ~r_active;
            r_valid   <= 1'b1;
            // A commit landing on the swap cycle queues for the next frame.
            r_pending <= I_lut_commit;
        end else if (I_lut_commit) begin
            r_pending <= 1'b1;
        end
    end

    assign w_bypass = DOUT_W'(pad_msb(32'(r_data_s1), DIN_W, DOUT_W));

    always_comb begin
        w_pix_out = '0;
        if (r_de_s1) begin
            w_pix_out = r_valid_s1 ? w_ram_q : w_bypass;
        end
    end

    // valid travels with the RAM read so a swap-cycle pixel is not mapped through the old bank.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_vs_s1    <= 1'b0;
            r_hs_s1    <= 1'b0;
            r_de_s1    <= 1'b0;
            r_valid_s1 <= 1'b0;
            r_data_s1  <= '0;
            r_vs_s2    <= 1'b0;
            r_hs_s2    <= 1'b0;
            r_de_s2    <= 1'b0;
            r_data_s2  <= '0;
        end else begin
            r_vs_s1    <= I_vs;
            r_hs_s1    <= I_hs;
            r_de_s1    <= I_de;
            r_valid_s1 <= r_valid;
            r_data_s1  <= I_data;
            r_vs_s2    <= r_vs_s1;
            r_hs_s2    <= r_hs_s1;
            r_de_s2    <= r_de_s1;
            r_data_s2  <= w_pix_out;
        end
    end

    assign O_vs        = r_vs_s2;
    assign O_hs        = r_hs_s2;
    assign O_de        = r_de_s2;
    assign O_data      = r_data_s2;
    assign O_lut_busy  = r_pending;
    assign O_lut_bank  = r_active;
    assign O_lut_valid = r_valid;

endmodule

`default_nettype wire
